// File: rtl/n25q_cmd_seq.sv
// N25Q serial-flash command sequencer: frames one instruction (opcode, address,
// dummy and data phases) onto a byte-wide SPI shift engine and drives chip select.
module n25q_cmd_seq #(
    parameter int unsigned ADDR_BYTES = 3,
    parameter int unsigned CSH_CYCLES = 4
) (
    input  logic        ifclk,
    input  logic        resetb,
    input  logic        cmd_go,
    input  logic [7:0]  cmd_opcode,
    input  logic        cmd_has_addr,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_dummy,
    input  logic        cmd_dir,
    input  logic [8:0]  cmd_len,
    output logic        cmd_busy,
    output logic        cmd_done,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        spi_go,
    output logic [7:0]  spi_datai,
    input  logic [7:0]  spi_datao,
    input  logic        spi_busy,
    input  logic        spi_done,
    output logic        csb
);

    typedef enum logic [2:0] {
        IDLE,
        CSLOW,
        OPCODE,
        ADDR,
        DUMMY,
        DATA,
        CSHIGH
    } state_e;

    localparam int unsigned ADDR_SHIFT = 32 - ADDR_BYTES * 8;
    localparam logic [8:0]  ADDR_CNT   = 9'(ADDR_BYTES);
    localparam logic [8:0]  CSH_LAST   = 9'(CSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic        wait_q, wait_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  opcode_q, opcode_d;
    logic        has_addr_q, has_addr_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  dummy_q, dummy_d;
    logic        dir_q, dir_d;
    logic [8:0]  len_q, len_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wr_ready_q, wr_ready_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        spi_go_q, spi_go_d;
    logic [7:0]  spi_datai_q, spi_datai_d;
    logic        csb_q, csb_d;

    logic        issue;
    logic [7:0]  issue_byte;
    logic        advance;
    state_e      nxt;
    state_e      after_dummy, after_addr, after_op;
    logic [8:0]  cnt_inc;

    assign cnt_inc     = cnt_q + 9'd1;
    assign after_dummy = (len_q != 9'd0) ? DATA : CSHIGH;
    assign after_addr  = (dummy_q != 4'd0) ? DUMMY : after_dummy;
    assign after_op    = has_addr_q ? ADDR : after_addr;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        opcode_d    = opcode_q;
        has_addr_d  = has_addr_q;
        addr_d      = addr_q;
        dummy_d     = dummy_q;
        dir_d       = dir_q;
        len_d       = len_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        wr_ready_d  = 1'b0;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        spi_go_d    = 1'b0;
        spi_datai_d = spi_datai_q;
        csb_d       = csb_q;
        issue       = 1'b0;
        issue_byte  = '0;
        advance     = 1'b0;
        nxt         = state_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_go) begin
                    opcode_d   = cmd_opcode;
                    has_addr_d = cmd_has_addr;
                    addr_d     = cmd_addr << ADDR_SHIFT;
                    dummy_d    = cmd_dummy;
                    dir_d      = cmd_dir;
                    len_d      = cmd_len;
                    busy_d     = 1'b1;
                    csb_d      = 1'b0;
                    cnt_d      = '0;
                    wait_d     = 1'b0;
                    state_d    = CSLOW;
                end
            end
            // The opcode is launched straight out of CSLOW so csb leads spi_go by one cycle.
            CSLOW: begin
                if (!spi_busy) begin
                    issue      = 1'b1;
                    issue_byte = opcode_q;
                    state_d    = OPCODE;
                end
            end
            OPCODE, ADDR, DUMMY, DATA: begin
                if (wait_q) begin
                    if (spi_done) begin
                        wait_d = 1'b0;
                        cnt_d  = cnt_inc;
                        unique case (state_q)
                            OPCODE: begin
                                advance = 1'b1;
                                nxt     = after_op;
                            end
                            ADDR: begin
                                advance = (cnt_inc == ADDR_CNT);
                                nxt     = after_addr;
                            end
                            DUMMY: begin
                                advance = (cnt_inc == {5'd0, dummy_q});
                                nxt     = after_dummy;
                            end
                            default: begin
                                if (dir_q) begin
                                    rd_data_d  = spi_datao;
                                    rd_valid_d = 1'b1;
                                end
                                advance = (cnt_inc == len_q);
                                nxt     = CSHIGH;
                            end
                        endcase
                    end
                end else if (!spi_busy) begin
                    unique case (state_q)
                        ADDR: begin
                            issue      = 1'b1;
                            issue_byte = addr_q[31:24];
                            addr_d     = addr_q << 8;
                        end
                        DUMMY: begin
                            issue = 1'b1;
                        end
                        DATA: begin
                            if (dir_q) begin
                                issue = 1'b1;
                            end else if (wr_valid) begin
                                issue      = 1'b1;
                                issue_byte = wr_data;
                                wr_ready_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CSHIGH: begin
                if (cnt_q == CSH_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_inc;
                    done_d = (cnt_inc == CSH_LAST);
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            spi_go_d    = 1'b1;
            spi_datai_d = issue_byte;
            wait_d      = 1'b1;
        end

        if (advance) begin
            state_d = nxt;
            cnt_d   = '0;
            if (nxt == CSHIGH) begin
                csb_d  = 1'b1;
                done_d = (CSH_CYCLES == 1);
            end
        end
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= IDLE;
            wait_q      <= 1'b0;
            cnt_q       <= '0;
            opcode_q    <= '0;
            has_addr_q  <= 1'b0;
            addr_q      <= '0;
            dummy_q     <= '0;
            dir_q       <= 1'b0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            spi_go_q    <= 1'b0;
            spi_datai_q <= '0;
            csb_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cnt_q       <= cnt_d;
            opcode_q    <= opcode_d;
            has_addr_q  <= has_addr_d;
            addr_q      <= addr_d;
            dummy_q     <= dummy_d;
            dir_q       <= dir_d;
            len_q       <= len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wr_ready_q  <= wr_ready_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            spi_go_q    <= spi_go_d;
            spi_datai_q <= spi_datai_d;
            csb_q       <= csb_d;
        end
    end

    assign cmd_busy  = busy_q;
    assign cmd_done  = done_q;
    assign wr_ready  = wr_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign spi_go    = spi_go_q;
    assign spi_datai = spi_datai_q;
    assign csb       = csb_q;

endmodule
